// File: rtl/result_fifo_monitor.sv
// Result sink for the ornek1 accumulator: a first-word-fall-through FIFO with a valid/ready drain,
// plus saturating counters for over-threshold results and for results lost on overflow.
module result_fifo_monitor #(
  parameter int DEPTH  = 4,
  parameter int THRESH = 60,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [9:0]       in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [9:0]       out_data_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] over_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [9:0] THRESH_V = 10'(THRESH);

  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // The extra pointer bit lets the difference of the pointers tell full from empty.
  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == PW'(DEPTH));
  assign in_ready_o  = !full;
  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = in_valid_i & (!full | pop);
  assign drop        = in_valid_i & full & !pop;
  assign rd_ptr_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data_i;
    end
  end

  // out_data_o mirrors the head slot in a register so it resets cleanly and never sees in_data_i combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_data_o <= '0;
      over_cnt_o <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
        if (count > PW'(1)) begin
          out_data_o <= mem[rd_ptr_next[AW-1:0]];
        end else if (push) begin
          out_data_o <= in_data_i;
        end
      end else if (!out_valid_o && push) begin
        out_data_o <= in_data_i;
      end
      if (push && (in_data_i > THRESH_V) && (over_cnt_o != '1)) begin
        over_cnt_o <= over_cnt_o + 1'b1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) begin
          drop_cnt_o <= drop_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_fifo_monitor.sv
// Self-checking bench for result_fifo_monitor: directed scenarios plus a random phase,
// all compared against a queue-based model of the FIFO and its counters.
module tb_result_fifo_monitor;

  localparam int DEPTH  = 4;
  localparam int THRESH = 60;
  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid_i = 1'b0;
  logic [9:0]       in_data_i = '0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [9:0]       out_data_o;
  logic             out_ready_i = 1'b0;
  logic [CNT_W-1:0] over_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the FIFO in order, and the three status values.
  int q[$];
  int m_over = 0;
  int m_drop = 0;
  int m_ovf  = 0;

  result_fifo_monitor #(.DEPTH(DEPTH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_ready_i(out_ready_i),
    .over_cnt_o(over_cnt_o),
    .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out_valid"}, 32'(out_valid_o), 32'(q.size() != 0));
    checkValue({tag, ".in_ready"}, 32'(in_ready_o), 32'(q.size() < DEPTH));
    if (q.size() != 0) begin
      checkValue({tag, ".out_data"}, 32'(out_data_o), 32'(q[0]));
    end
    checkValue({tag, ".over_cnt"}, 32'(over_cnt_o), 32'(m_over));
    checkValue({tag, ".drop_cnt"}, 32'(drop_cnt_o), 32'(m_drop));
    checkValue({tag, ".overflow"}, 32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic modelReset();
    q.delete();
    m_over = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  // One clock of traffic: drive at the falling edge, advance the model, check 1 time unit after the rising edge.
  task automatic applyStimulus(input string tag, input bit v, input int d, input bit r);
    bit do_pop;
    bit do_push;
    @(negedge clk);
    in_valid_i  = v;
    in_data_i   = 10'(d);
    out_ready_i = r;
    do_pop  = (q.size() != 0) && r;
    do_push = v && ((q.size() < DEPTH) || do_pop);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(d);
      if (d > THRESH && m_over < SAT) m_over++;
    end else if (v) begin
      m_ovf = 1;
      if (m_drop < SAT) m_drop++;
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset and idle
    doReset();
    checkValue("reset.out_data", 32'(out_data_o), 32'd0);
    checkOutput("reset");
    applyStimulus("idle", 1'b0, 0, 1'b1);

    // Single push/pop; 60 is not above threshold
    applyStimulus("single.push", 1'b1, 60, 1'b0);
    checkValue("single.data60", 32'(out_data_o), 32'd60);
    checkValue("single.over0", 32'(over_cnt_o), 32'd0);
    applyStimulus("single.pop", 1'b0, 0, 1'b1);
    checkValue("single.empty", 32'(out_valid_o), 32'd0);

    // Fill and overflow
    applyStimulus("fill.1", 1'b1, 61, 1'b0);
    applyStimulus("fill.2", 1'b1, 100, 1'b0);
    applyStimulus("fill.3", 1'b1, 12, 1'b0);
    applyStimulus("fill.4", 1'b1, 75, 1'b0);
    checkValue("fill.full", 32'(in_ready_o), 32'd0);
    applyStimulus("fill.5", 1'b1, 90, 1'b0);
    checkValue("fill.drop1", 32'(drop_cnt_o), 32'd1);
    checkValue("fill.ovf", 32'(overflow_o), 32'd1);
    checkValue("fill.over3", 32'(over_cnt_o), 32'd3);
    checkValue("drain.h0", 32'(out_data_o), 32'd61);
    applyStimulus("drain.1", 1'b0, 0, 1'b1);
    checkValue("drain.h1", 32'(out_data_o), 32'd100);
    applyStimulus("drain.2", 1'b0, 0, 1'b1);
    checkValue("drain.h2", 32'(out_data_o), 32'd12);
    applyStimulus("drain.3", 1'b0, 0, 1'b1);
    checkValue("drain.h3", 32'(out_data_o), 32'd75);
    applyStimulus("drain.4", 1'b0, 0, 1'b1);

    // Push and pop in the same cycle while full
    for (int k = 1; k <= 4; k++) applyStimulus("pp.fill", 1'b1, k, 1'b0);
    applyStimulus("pp.both", 1'b1, 5, 1'b1);
    checkValue("pp.nodrop", 32'(drop_cnt_o), 32'd1);
    checkValue("pp.stillfull", 32'(in_ready_o), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      checkValue("pp.order", 32'(out_data_o), 32'(k));
      applyStimulus("pp.drain", 1'b0, 0, 1'b1);
    end

    // Pointer wrap under streaming
    doReset();
    for (int k = 1; k <= 20; k++) begin
      applyStimulus("stream", 1'b1, k * 10, 1'b1);
      checkValue("stream.head", 32'(out_data_o), 32'(k * 10));
    end
    applyStimulus("stream.tail", 1'b0, 0, 1'b1);
    checkValue("stream.drop0", 32'(drop_cnt_o), 32'd0);
    checkValue("stream.over14", 32'(over_cnt_o), 32'd14);

    // Reset while holding words, then saturate the over-threshold counter
    for (int k = 0; k < 3; k++) applyStimulus("hold", 1'b1, 200 + k, 1'b0);
    @(negedge clk);
    in_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    checkValue("midrst.valid", 32'(out_valid_o), 32'd0);
    checkValue("midrst.ready", 32'(in_ready_o), 32'd1);
    checkValue("midrst.over", 32'(over_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("newhead", 1'b1, 7, 1'b0);
    checkValue("newhead.data", 32'(out_data_o), 32'd7);
    for (int k = 0; k < 300; k++) applyStimulus("sat", 1'b1, 500, 1'b1);
    checkValue("sat.over255", 32'(over_cnt_o), 32'd255);

    // Random traffic
    doReset();
    for (int k = 0; k < 400; k++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
